ball_motion_ctrl: RTL and testbench

//  Upstream stage of the frame buffer. Owns the ball position and direction.

---
 rtl/ball_pkg.sv | 29 ++
 rtl/ball_motion_ctrl_tick_divider.sv | 44 ++++
 rtl/ball_motion_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared ball definitions: direction encoding, screen defaults and coordinate
// width, used by the motion controller, frame buffer and input decoder.
package ball_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned DIR_W   = 2;
    localparam int unsigned SIZE_W  = 7;

    localparam int unsigned DEF_SCREEN_W = 320;
    localparam int unsigned DEF_SCREEN_H = 240;

    localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b01;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b11;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [DIR_W-1:0]   dir;
    } ball_state_t;

    // Largest legal top-left coordinate so the ball (size+1 pixels) stays on screen.
    function automatic logic [COORD_W-1:0] edge_limit(input int unsigned extent,
                                                      input logic [SIZE_W-1:0] size);
        return COORD_W'(extent - 32'(size) - 1);
    endfunction

endpackage

// File: rtl/ball_motion_ctrl_tick_divider.sv
// Motion tick divider: one-cycle tick every TICK_DIV enabled cycles; the count
// is held at zero whenever en is low.
module tick_divider #(
    parameter int unsigned TICK_DIV = 833333
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned     CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (en) begin
            if (cnt_q == CNT_LAST) begin
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball position/direction owner: moves the ball STEP pixels per motion tick and
// strobes write_enable for the repaint. Define BALL_WRAP_EN to wrap at edges.
module ball_motion_ctrl
    import ball_pkg::*;
#(
    parameter int unsigned       SCREEN_W  = DEF_SCREEN_W,
    parameter int unsigned       SCREEN_H  = DEF_SCREEN_H,
    parameter int unsigned       TICK_DIV  = 833333,
    parameter int unsigned       START_X   = 150,
    parameter int unsigned       START_Y   = 110,
    parameter logic [DIR_W-1:0]  START_DIR = DIR_RIGHT
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               run,
    input  logic               dir_req_valid,
    input  logic [DIR_W-1:0]   dir_req,
    input  logic [SIZE_W-1:0]  SIZE,
    input  logic [SIZE_W-1:0]  STEP,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [DIR_W-1:0]   ball_direction,
    output logic               write_enable,
    output logic               tick_o
);

    localparam int unsigned SUM_W = COORD_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_MOVE,
        ST_PAINT
    } state_t;

    state_t             state_q;
    state_t             state_d;
    ball_state_t        ball_q;
    ball_state_t        ball_d;
    ball_state_t        ball_moved;
    logic               pend_valid_q;
    logic               pend_valid_d;
    logic [DIR_W-1:0]   pend_dir_q;
    logic [DIR_W-1:0]   pend_dir_d;
    logic               we_q;
    logic               we_d;
    logic               tick;

    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_max;
    logic [COORD_W-1:0] step;
    logic [SUM_W-1:0]   x_sum;
    logic [SUM_W-1:0]   y_sum;
    logic [DIR_W-1:0]   dir_eff;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk  (CLOCK_50),
        .rst  (reset),
        .en   (run),
        .tick (tick)
    );

    // Next position: pending request wins over the current direction, then the
    // edge test runs before any subtraction so nothing underflows.
    always_comb begin
        x_max   = edge_limit(SCREEN_W, SIZE);
        y_max   = edge_limit(SCREEN_H, SIZE);
        step    = COORD_W'(STEP);
        x_sum   = SUM_W'(ball_q.x) + SUM_W'(STEP);
        y_sum   = SUM_W'(ball_q.y) + SUM_W'(STEP);
        dir_eff = pend_valid_q ? pend_dir_q : ball_q.dir;

        ball_moved     = ball_q;
        ball_moved.dir = dir_eff;

        case (dir_eff)
            DIR_UP: begin
                if (ball_q.y < step) begin
`ifdef BALL_WRAP_EN
                    ball_moved.y   = y_max;
`else
                    ball_moved.y   = '0;
                    ball_moved.dir = DIR_DOWN;
`endif
                end else begin
                    ball_moved.y = ball_q.y - step;
                end
            end
            DIR_DOWN: begin
                if (y_sum > SUM_W'(y_max)) begin
`ifdef BALL_WRAP_EN
                    ball_moved.y   = '0;
`else
                    ball_moved.y   = y_max;
                    ball_moved.dir = DIR_UP;
`endif
                end else begin
                    ball_moved.y = y_sum[COORD_W-1:0];
                end
            end
            DIR_LEFT: begin
                if (ball_q.x < step) begin
`ifdef BALL_WRAP_EN
                    ball_moved.x   = x_max;
`else
                    ball_moved.x   = '0;
                    ball_moved.dir = DIR_RIGHT;
`endif
                end else begin
                    ball_moved.x = ball_q.x - step;
                end
            end
            default: begin
                if (x_sum > SUM_W'(x_max)) begin
`ifdef BALL_WRAP_EN
                    ball_moved.x   = '0;
`else
                    ball_moved.x   = x_max;
                    ball_moved.dir = DIR_LEFT;
`endif
                end else begin
                    ball_moved.x = x_sum[COORD_W-1:0];
                end
            end
        endcase
    end

    // Frame sequencing; a strobe seen in MOVE survives the clear and waits a tick.
    always_comb begin
        state_d      = state_q;
        ball_d       = ball_q;
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
        we_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                ball_d       = ball_moved;
                pend_valid_d = 1'b0;
                we_d         = 1'b1;
                state_d      = ST_PAINT;
            end
            ST_PAINT: begin
                state_d = run ? ST_WAIT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (dir_req_valid) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = dir_req;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ball_q       <= '{x: COORD_W'(START_X), y: COORD_W'(START_Y), dir: START_DIR};
            pend_valid_q <= 1'b0;
            pend_dir_q   <= DIR_UP;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            ball_q       <= ball_d;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
            we_q         <= we_d;
        end
    end

    assign ball_x         = ball_q.x;
    assign ball_y         = ball_q.y;
    assign ball_direction = ball_q.dir;
    assign write_enable   = we_q;
    assign tick_o         = tick;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl (TICK_DIV=4) against a per-tick
// behavioural model; follows BALL_WRAP_EN when defined.
module tb_ball_motion_ctrl;
    import ball_pkg::*;

    localparam int unsigned TICK_DIV = 4;
    localparam int          MAX_WAIT = 64;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        run;
    logic        dir_req_valid;
    logic [1:0]  dir_req;
    logic [6:0]  SIZE;
    logic [6:0]  STEP;
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic [1:0]  ball_direction;
    logic        write_enable;
    logic        tick_o;

    int checks   = 0;
    int failures = 0;

    // Model state: position, direction and the 1-deep pending request.
    int m_x;
    int m_y;
    int m_dir;
    bit m_pv;
    int m_pd;

    ball_motion_ctrl #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .run            (run),
        .dir_req_valid  (dir_req_valid),
        .dir_req        (dir_req),
        .SIZE           (SIZE),
        .STEP           (STEP),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .ball_direction (ball_direction),
        .write_enable   (write_enable),
        .tick_o         (tick_o)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_x = 150; m_y = 110; m_dir = 3; m_pv = 0; m_pd = 0;
    endtask

    task automatic model_move(input int step, input int size);
        int xmax;
        int ymax;
        xmax = int'(DEF_SCREEN_W) - 1 - size;
        ymax = int'(DEF_SCREEN_H) - 1 - size;
        if (m_pv) begin m_dir = m_pd; m_pv = 0; end
        case (m_dir)
            0: if (m_y - step < 0) begin
`ifdef BALL_WRAP_EN
                   m_y = ymax;
`else
                   m_y = 0; m_dir = 1;
`endif
               end else m_y = m_y - step;
            1: if (m_y + step > ymax) begin
`ifdef BALL_WRAP_EN
                   m_y = 0;
`else
                   m_y = ymax; m_dir = 0;
`endif
               end else m_y = m_y + step;
            2: if (m_x - step < 0) begin
`ifdef BALL_WRAP_EN
                   m_x = xmax;
`else
                   m_x = 0; m_dir = 3;
`endif
               end else m_x = m_x - step;
            default: if (m_x + step > xmax) begin
`ifdef BALL_WRAP_EN
                   m_x = 0;
`else
                   m_x = xmax; m_dir = 2;
`endif
               end else m_x = m_x + step;
        endcase
    endtask

    // req: -1 none, -2 random (25% chance), 0..3 strobe that direction.
    task automatic drive_req(input int req);
        int r;
        r = req;
        if (r == -2) r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
        if (r >= 0) begin
            dir_req_valid = 1'b1;
            dir_req       = 2'(r);
            m_pv = 1; m_pd = r;
        end else begin
            dir_req_valid = 1'b0;
        end
    endtask

    task automatic pre_strobe(input int d);
        @(negedge CLOCK_50);
        drive_req(d);
    endtask

    // One motion frame: wait for tick_o, then check MOVE (no write) and PAINT.
    task automatic frame(input int step, input int size, input int wait_req,
                         input int move_req, output int waited);
        bit seen;
        seen   = 0;
        waited = 0;
        STEP   = 7'(step);
        SIZE   = 7'(size);
        while (!seen && waited < MAX_WAIT) begin
            @(negedge CLOCK_50);
            waited++;
            drive_req(wait_req);
            if (tick_o === 1'b1) begin
                seen = 1;
            end else begin
                checks++;
                if (write_enable !== 1'b0) begin
                    failures++;
                    $display("FAIL we_while_waiting: write_enable=%b required 0", write_enable);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL tick_timeout: no tick_o within %0d cycles", MAX_WAIT);
            dir_req_valid = 1'b0;
            return;
        end
        model_move(step, size);

        @(negedge CLOCK_50);
        drive_req(move_req);
        checks++;
        if (write_enable !== 1'b0) begin
            failures++;
            $display("FAIL we_move_cycle: write_enable=%b required 0", write_enable);
        end

        @(negedge CLOCK_50);
        dir_req_valid = 1'b0;
        checks++;
        if (write_enable !== 1'b1) begin
            failures++;
            $display("FAIL we_paint_cycle: write_enable=%b required 1", write_enable);
        end
        checks++;
        if (ball_x !== 11'(m_x)) begin
            failures++;
            $display("FAIL frame_x: ball_x=%0d required %0d", ball_x, m_x);
        end
        checks++;
        if (ball_y !== 11'(m_y)) begin
            failures++;
            $display("FAIL frame_y: ball_y=%0d required %0d", ball_y, m_y);
        end
        checks++;
        if (ball_direction !== 2'(m_dir)) begin
            failures++;
            $display("FAIL frame_dir: ball_direction=%0d required %0d", ball_direction, m_dir);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; dir_req_valid = 1'b0; dir_req = 2'b00;
        SIZE = 7'd9; STEP = 7'd5;
        model_reset();
        repeat (2) @(negedge CLOCK_50);
        checks++;
        if (ball_x !== 11'd150 || ball_y !== 11'd110 || ball_direction !== 2'b11) begin
            failures++;
            $display("FAIL reset_pos: x=%0d y=%0d dir=%0d required 150 110 3", ball_x, ball_y, ball_direction);
        end
        checks++;
        if (write_enable !== 1'b0 || tick_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: we=%b tick=%b required 0 0", write_enable, tick_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_tick();
        int w;
        run = 1'b1;
        frame(5, 9, -1, -1, w);
        checks++;
        if (ball_x !== 11'd155 || ball_y !== 11'd110) begin
            failures++;
            $display("FAIL first_tick: x=%0d y=%0d required 155 110", ball_x, ball_y);
        end
    endtask

    task automatic test_bounce_right();
        int w;
        frame(127, 9, -1, -1, w);
        frame(23, 9, -1, -1, w);
        frame(8, 9, -1, -1, w);
        checks++;
`ifdef BALL_WRAP_EN
        if (ball_x !== 11'd0 || ball_direction !== DIR_RIGHT) begin
            failures++;
            $display("FAIL right_edge: x=%0d dir=%0d required 0 3", ball_x, ball_direction);
        end
`else
        if (ball_x !== 11'd310 || ball_direction !== DIR_LEFT) begin
            failures++;
            $display("FAIL right_edge: x=%0d dir=%0d required 310 2", ball_x, ball_direction);
        end
`endif
        frame(8, 9, -1, -1, w);
        checks++;
`ifdef BALL_WRAP_EN
        if (ball_x !== 11'd8) begin
`else
        if (ball_x !== 11'd302) begin
`endif
            failures++;
            $display("FAIL after_right_edge: x=%0d", ball_x);
        end
    endtask

    task automatic test_bounce_up();
        int w;
        pre_strobe(0);
        frame(107, 9, -1, -1, w);
        checks++;
        if (ball_y !== 11'd3 || ball_direction !== DIR_UP) begin
            failures++;
            $display("FAIL up_approach: y=%0d dir=%0d required 3 0", ball_y, ball_direction);
        end
        frame(5, 9, -1, -1, w);
        checks++;
`ifdef BALL_WRAP_EN
        if (ball_y !== 11'd230 || ball_direction !== DIR_UP) begin
            failures++;
            $display("FAIL top_edge: y=%0d dir=%0d required 230 0", ball_y, ball_direction);
        end
`else
        if (ball_y !== 11'd0 || ball_direction !== DIR_DOWN) begin
            failures++;
            $display("FAIL top_edge: y=%0d dir=%0d required 0 1", ball_y, ball_direction);
        end
`endif
    endtask

    task automatic test_dir_requests();
        int w;
        pre_strobe(0);
        frame(4, 9, 2, 0, w);
        checks++;
        if (ball_direction !== DIR_LEFT) begin
            failures++;
            $display("FAIL req_overwrite: dir=%0d required 2", ball_direction);
        end
        frame(4, 9, -1, -1, w);
        checks++;
`ifdef BALL_WRAP_EN
        if (ball_direction !== DIR_UP || ball_y !== 11'd226) begin
            failures++;
            $display("FAIL req_held_from_move: dir=%0d y=%0d required 0 226", ball_direction, ball_y);
        end
`else
        if (ball_direction !== DIR_DOWN || ball_y !== 11'd0) begin
            failures++;
            $display("FAIL req_held_from_move: dir=%0d y=%0d required 1 0", ball_direction, ball_y);
        end
`endif
    endtask

    task automatic test_step_zero();
        int w;
        frame(0, 9, -1, -1, w);
        frame(0, 40, -1, -1, w);
    endtask

    task automatic test_back_to_back();
        int w;
        for (int i = 0; i < 3; i++) begin
            frame(int'($urandom_range(0, 20)), 9, -1, -1, w);
            checks++;
            if (w !== int'(TICK_DIV) - 2) begin
                failures++;
                $display("FAIL tick_period: waited %0d cycles required %0d", w, TICK_DIV - 2);
            end
        end
    endtask

    task automatic test_run_pause();
        int w;
        @(negedge CLOCK_50);
        run = 1'b0;
        for (int i = 0; i < 10 * int'(TICK_DIV); i++) begin
            @(negedge CLOCK_50);
            checks++;
            if (write_enable !== 1'b0 || tick_o !== 1'b0) begin
                failures++;
                $display("FAIL paused_strobe: cycle %0d we=%b tick=%b required 0 0", i, write_enable, tick_o);
            end
        end
        checks++;
        if (ball_x !== 11'(m_x) || ball_y !== 11'(m_y) || ball_direction !== 2'(m_dir)) begin
            failures++;
            $display("FAIL paused_pos: x=%0d y=%0d dir=%0d required %0d %0d %0d",
                     ball_x, ball_y, ball_direction, m_x, m_y, m_dir);
        end
        run = 1'b1;
        frame(6, 9, -1, -1, w);
    endtask

    task automatic test_reset_mid_paint();
        int w;
        frame(3, 9, -1, -1, w);
        reset = 1'b1;
        dir_req_valid = 1'b1;
        dir_req = 2'b00;
        @(negedge CLOCK_50);
        checks++;
        if (ball_x !== 11'd150 || ball_y !== 11'd110 || ball_direction !== 2'b11 || write_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_paint: x=%0d y=%0d dir=%0d we=%b required 150 110 3 0",
                     ball_x, ball_y, ball_direction, write_enable);
        end
        dir_req_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        frame(5, 9, -1, -1, w);
        checks++;
        if (ball_x !== 11'd155 || ball_direction !== DIR_RIGHT) begin
            failures++;
            $display("FAIL pending_cleared_by_reset: x=%0d dir=%0d required 155 3", ball_x, ball_direction);
        end
    endtask

    task automatic test_random();
        int w;
        int step;
        for (int i = 0; i < 40; i++) begin
            step = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 127)) : int'($urandom_range(0, 30));
            frame(step, int'($urandom_range(0, 127)), -2, -2, w);
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_bounce_right();
        test_bounce_up();
        test_dir_requests();
        test_step_zero();
        test_back_to_back();
        test_run_pause();
        test_reset_mid_paint();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
